fir_128_mdc_fsm: RTL
====================

// Module: fir_128_mdc_fsm
// PURPOSE
//   Job sequencer for the FIR-128 HWPE. Sits between the control/regfile slave and the streamer + engine.
//   On a trigger it latches job registers and clears the engine. It programs the y_V sink, then the x_V source.
//   It counts output handshakes and ends the job with a done pulse, which the ctrl turns into the core event.
// PARAMETERS
//   ADDR_WIDTH  32   TCDM byte-address width of the base addresses
//   LEN_WIDTH   16   width of the sample-count (job length) field
//   WDOG_WIDTH  20   watchdog counter width (used only with the optional feature)
// PORTS
//   clk_i           in   1           clock
//   rst_ni          in   1           asynchronous reset, active-low
//   clear_i         in   1           synchronous soft clear from ctrl
//   start_i         in   1           job trigger pulse from ctrl
//   x_base_i        in   ADDR_WIDTH  x_V source base address
//   y_base_i        in   ADDR_WIDTH  y_V sink base address
//   len_i           in   LEN_WIDTH   samples per job (32-bit words)
//   x_req_o         out  1           x_V source request (one-cycle pulse)
//   x_addr_o        out  ADDR_WIDTH  x_V source base, valid while x_req_o
//   x_len_o         out  LEN_WIDTH   x_V source length, valid while x_req_o
//   x_done_i        in   1           x_V source finished (pulse)
//   y_req_o         out  1           y_V sink request (one-cycle pulse)
//   y_addr_o        out  ADDR_WIDTH  y_V sink base, valid while y_req_o
//   y_len_o         out  LEN_WIDTH   y_V sink length, valid while y_req_o
//   y_done_i        in   1           y_V sink finished (pulse)
//   y_valid_i       in   1           snoop of y_V stream valid
//   y_ready_i       in   1           snoop of y_V stream ready
//   eng_clear_o     out  1           engine clear (one-cycle pulse)
//   busy_o          out  1           job in progress
//   done_o          out  1           job complete (one-cycle pulse)
//   err_o           out  1           sticky error, cleared by next accepted start_i or clear_i
//   out_cnt_o       out  LEN_WIDTH   output handshakes counted in the current job
// BEHAVIOUR
//   - Reset (rst_ni=0, async): state IDLE; every output 0; job registers 0.
//   - States: IDLE, CLR, PROG_Y, PROG_X, RUN, DONE, ERR.
//   - IDLE: start_i=1 latches x_base_i, y_base_i and len_i, clears out_cnt and err_o, then branches on len_i.
//     - len_i==0: go to DONE directly. No request or eng_clear_o is issued.
//     - otherwise: go to CLR.
//   - CLR: eng_clear_o=1 for exactly 1 cycle, then PROG_Y.
//   - PROG_Y: y_req_o=1 for 1 cycle, with latched y_base and len. Then PROG_X.
//   - PROG_X: x_req_o=1 for 1 cycle, with latched x_base and len. Then RUN.
//   - The sink is always armed before the source, so no output is lost.
//   - busy_o=1 in every state except IDLE.
//   - RUN:
//     - out_cnt increments on each cycle with y_valid_i & y_ready_i, saturating at len.
//     - x_done_i and y_done_i are each latched into a sticky flag; both may arrive in the same cycle.
//     - Both flags set and out_cnt==len: go to DONE.
//     - y_done_i seen while out_cnt!=len (counted in the same cycle): go to ERR.
//   - DONE: done_o=1 for 1 cycle, then IDLE. busy_o drops in the cycle after done_o.
//   - Start-to-first-request latency is fixed: start_i in cycle 0, eng_clear_o in 1, y_req_o in 2, x_req_o in 3.
//   - ERR: err_o=1 (sticky) and done_o=1 for 1 cycle, then IDLE.
//   - start_i while busy_o=1 is ignored, with no effect on latched job registers.
//   - clear_i in any state: next cycle IDLE; counters, flags and err_o cleared; no done_o. clear_i beats start_i.
//   - out_cnt_o holds its final value in IDLE until the next accepted start_i.
// CONFIGURATION
//   FIR_128_MDC_FSM_WDOG_EN defined:
//   - A WDOG_WIDTH-bit counter resets on entry to RUN and on any y_valid_i & y_ready_i.
//   - Otherwise it increments each RUN cycle.
//   - On all-ones it sends RUN to ERR.
//   Macro undefined: no watchdog logic; RUN waits indefinitely.
// TESTING
//   - Reset mid-RUN: len=8, assert rst_ni=0 after 3 outputs -> all outputs 0 immediately; a new start_i runs cleanly.
//   - Nominal: len=128, x_base=0x1000, y_base=0x2000.
//     - Expect eng_clear_o at cycle 1, y_req_o at 2 with addr 0x2000 and len 128, x_req_o at 3 with addr 0x1000.
//     - 128 handshakes, both done pulses -> single done_o, out_cnt_o=128, err_o=0.
//   - Zero length: start_i with len=0 -> done_o 1 cycle later, no x_req_o, y_req_o or eng_clear_o.
//   - Short output: len=16, y_done_i after 15 handshakes -> ERR, err_o=1, done_o pulse. Next start_i clears err_o.
//   - Ordering: x_done_i and y_done_i in the same cycle, with the 16th handshake for len=16 -> DONE, err_o=0.
//   - Start while busy, then clear: start_i during RUN -> no new requests; clear_i -> IDLE next cycle, busy_o=0, no done_o.
//   - WDOG_EN, WDOG_WIDTH=4: no handshakes for 15 RUN cycles -> ERR, err_o=1.

Source files
------------

// File: rtl/fir_128_mdc_fsm.sv
// -----------------------------------------------------------------------------
// fir_128_mdc_fsm
//
// Job sequencer for the FIR-128 HWPE. It sits between the control/regfile
// slave and the streamer + engine. A start pulse latches the job registers and
// clears the engine. The y_V sink is programmed first and the x_V source
// second, so no output sample can be lost. The block then counts y_V output
// handshakes and ends the job with a one-cycle done pulse.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   clear_i                  synchronous soft clear (wins over start_i)
//   start_i                  job trigger, ignored while busy_o
//   x_base_i, y_base_i       source / sink base addresses
//   len_i                    samples per job (0 = finish immediately)
//   x_req_o/x_addr_o/x_len_o source request pulse with its address and length
//   y_req_o/y_addr_o/y_len_o sink request pulse with its address and length
//   x_done_i, y_done_i       source / sink finished pulses
//   y_valid_i, y_ready_i     snoop of the y_V output stream handshake
//   eng_clear_o              engine clear pulse
//   busy_o                   job in progress
//   done_o                   job finished (one cycle, also on error)
//   err_o                    sticky error flag
//   out_cnt_o                output handshakes counted in the current job
//
// Optional feature
//   FIR_128_MDC_FSM_WDOG_EN : adds a WDOG_WIDTH-bit watchdog that aborts RUN
//   into ERR after a long stretch without any output handshake.
// -----------------------------------------------------------------------------
module fir_128_mdc_fsm #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int WDOG_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] x_base_i,
  input  logic [ADDR_WIDTH-1:0] y_base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  x_req_o,
  output logic [ADDR_WIDTH-1:0] x_addr_o,
  output logic [LEN_WIDTH-1:0]  x_len_o,
  input  logic                  x_done_i,
  output logic                  y_req_o,
  output logic [ADDR_WIDTH-1:0] y_addr_o,
  output logic [LEN_WIDTH-1:0]  y_len_o,
  input  logic                  y_done_i,
  input  logic                  y_valid_i,
  input  logic                  y_ready_i,
  output logic                  eng_clear_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [LEN_WIDTH-1:0]  out_cnt_o
);

  typedef enum logic [2:0] {IDLE, CLR, PROG_Y, PROG_X, RUN, DONE, ERR} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] x_base_q, y_base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  x_seen_q, y_seen_q;
  logic                  x_seen_d, y_seen_d;
  logic                  err_q;
  logic                  handshake;
  logic                  start_accept;
  logic                  wdog_expired;

  assign handshake    = y_valid_i & y_ready_i;
  assign start_accept = (state_q == IDLE) && start_i && !clear_i;

  // The completion test in RUN must see this cycle's handshake and done
  // pulses, so the next values of the counter and sticky flags are formed here.
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (handshake && (out_cnt_q != len_q)) begin
      out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
    end
    x_seen_d = x_seen_q | x_done_i;
    y_seen_d = y_seen_q | y_done_i;
  end

`ifdef FIR_128_MDC_FSM_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q;

  // Watchdog sits at zero outside RUN, so it starts from zero on RUN entry,
  // and restarts on every output handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if (clear_i || (state_q != RUN) || handshake) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WDOG_WIDTH'(1);
    end
  end

  assign wdog_expired = (wdog_q == '1);
`else
  assign wdog_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. An early y_done_i is checked before completion so a
  // short output stream always ends in ERR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : CLR;
      CLR:     state_d = PROG_Y;
      PROG_Y:  state_d = PROG_X;
      PROG_X:  state_d = RUN;
      RUN: begin
        if (y_done_i && (out_cnt_d != len_q)) begin
          state_d = ERR;
        end else if (x_seen_d && y_seen_d && (out_cnt_d == len_q)) begin
          state_d = DONE;
        end else if (wdog_expired) begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
    end
  end

  // Job registers, output counter, sticky flags and error flag. Job registers
  // only move on an accepted start, so starts while busy leave them alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_base_q  <= '0;
      y_base_q  <= '0;
      len_q     <= '0;
      out_cnt_q <= '0;
      x_seen_q  <= 1'b0;
      y_seen_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      out_cnt_q <= '0;
      x_seen_q  <= 1'b0;
      y_seen_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (start_accept) begin
      x_base_q  <= x_base_i;
      y_base_q  <= y_base_i;
      len_q     <= len_i;
      out_cnt_q <= '0;
      x_seen_q  <= 1'b0;
      y_seen_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (state_q == RUN) begin
      out_cnt_q <= out_cnt_d;
      x_seen_q  <= x_seen_d;
      y_seen_q  <= y_seen_d;
      if (state_d == ERR) begin
        err_q <= 1'b1;
      end
    end
  end

  // Moore outputs decoded from the state; address/length buses are zero
  // whenever their request is low.
  always_comb begin
    eng_clear_o = (state_q == CLR);
    y_req_o     = (state_q == PROG_Y);
    x_req_o     = (state_q == PROG_X);
    y_addr_o    = y_req_o ? y_base_q : '0;
    y_len_o     = y_req_o ? len_q    : '0;
    x_addr_o    = x_req_o ? x_base_q : '0;
    x_len_o     = x_req_o ? len_q    : '0;
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE) || (state_q == ERR);
    err_o       = err_q;
    out_cnt_o   = out_cnt_q;
  end

endmodule
